write_bus_arbiter: RTL and testbench

- Shares the single register write bus between three result producers: requester 0 = ALU, 1 = load unit, 2 = multiplier.
- Round-robin arbitration picks one requester per cycle; the winning result is registered into a one-entry write stage.
- That write stage drives the bus-transfer forwarding network.
- From the write stage the block generates the three forwarding enables (write bus to left, right and third read buses) by comparing the staged destination with the current read-port register addresses.

---
 rtl/write_bus_arbiter.sv | 133 +++++++++++++
 tb/tb_write_bus_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_bus_arbiter.sv
// Round-robin arbiter for the shared register write bus (ALU, load unit, multiplier),
// with a one-entry write stage that drives the read-port forwarding enables.

module write_bus_arbiter #(
    parameter int WordWidth    = 32,
    parameter int RegAddrWidth = 4,
    parameter int NoForwardReg = 15
) (
    input  logic                      in_Clock,
    input  logic                      in_Reset,
    input  logic                      in_Stall,
    input  logic [2:0]                in_Req,
    input  logic [3*WordWidth-1:0]    in_ReqData,
    input  logic [3*RegAddrWidth-1:0] in_ReqDest,
    output logic [2:0]                out_Grant,
    output logic [WordWidth-1:0]      out_WriteBus,
    output logic [RegAddrWidth-1:0]   out_WriteDest,
    output logic                      out_WriteValid,
    input  logic [RegAddrWidth-1:0]   in_LeftReadAddr,
    input  logic [RegAddrWidth-1:0]   in_RightReadAddr,
    input  logic [RegAddrWidth-1:0]   in_ThirdReadAddr,
    input  logic                      in_LeftReadValid,
    input  logic                      in_RightReadValid,
    input  logic                      in_ThirdReadValid,
    output logic                      out_WriteToLeftRead,
    output logic                      out_WriteToRightRead,
    output logic                      out_WriteToThirdRead
);

    localparam logic [RegAddrWidth-1:0] NO_FWD_ADDR = RegAddrWidth'(NoForwardReg);

    // Pointer states: which requester is searched first this cycle.
    localparam logic [1:0] PTR_0 = 2'd0;
    localparam logic [1:0] PTR_1 = 2'd1;
    localparam logic [1:0] PTR_2 = 2'd2;

    logic [1:0]              ptr_q, ptr_d;
    logic                    valid_q, valid_d;
    logic [WordWidth-1:0]    data_q, data_d;
    logic [RegAddrWidth-1:0] dest_q, dest_d;

    logic [2:0]              grant;
    logic                    arb_enable;
    logic [WordWidth-1:0]    sel_data;
    logic [RegAddrWidth-1:0] sel_dest;
    logic                    fwd_base;

    assign arb_enable = !in_Reset && !in_Stall;

    always_comb begin
        grant = 3'b000;
        if (arb_enable) begin
            case (ptr_q)
                PTR_1: begin
                    if (in_Req[1])      grant = 3'b010;
                    else if (in_Req[2]) grant = 3'b100;
                    else if (in_Req[0]) grant = 3'b001;
                end
                PTR_2: begin
                    if (in_Req[2])      grant = 3'b100;
                    else if (in_Req[0]) grant = 3'b001;
                    else if (in_Req[1]) grant = 3'b010;
                end
                default: begin
                    if (in_Req[0])      grant = 3'b001;
                    else if (in_Req[1]) grant = 3'b010;
                    else if (in_Req[2]) grant = 3'b100;
                end
            endcase
        end
    end

    always_comb begin
        sel_data = '0;
        sel_dest = '0;
        for (int i = 0; i < 3; i++) begin
            if (grant[i]) begin
                sel_data = in_ReqData[i*WordWidth +: WordWidth];
                sel_dest = in_ReqDest[i*RegAddrWidth +: RegAddrWidth];
            end
        end
    end

    // A stall freezes everything; an idle unstalled cycle only drops valid, keeping data/dest.
    always_comb begin
        ptr_d   = ptr_q;
        valid_d = valid_q;
        data_d  = data_q;
        dest_d  = dest_q;
        if (!in_Stall) begin
            if (|grant) begin
                valid_d = 1'b1;
                data_d  = sel_data;
                dest_d  = sel_dest;
                case (grant)
                    3'b001:  ptr_d = PTR_1;
                    3'b010:  ptr_d = PTR_2;
                    3'b100:  ptr_d = PTR_0;
                    default: ptr_d = ptr_q;
                endcase
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge in_Clock) begin
        if (in_Reset) begin
            ptr_q   <= PTR_0;
            valid_q <= 1'b0;
            data_q  <= '0;
            dest_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            dest_q  <= dest_d;
        end
    end

    // The PC destination is written but never forwarded.
    assign fwd_base = valid_q && !in_Reset && (dest_q != NO_FWD_ADDR);

    assign out_WriteToLeftRead  = fwd_base && in_LeftReadValid  && (in_LeftReadAddr  == dest_q);
    assign out_WriteToRightRead = fwd_base && in_RightReadValid && (in_RightReadAddr == dest_q);
    assign out_WriteToThirdRead = fwd_base && in_ThirdReadValid && (in_ThirdReadAddr == dest_q);

    assign out_Grant      = grant;
    assign out_WriteBus   = data_q;
    assign out_WriteDest  = dest_q;
    assign out_WriteValid = valid_q;

endmodule

// File: tb/tb_write_bus_arbiter.sv
// Directed bench for write_bus_arbiter: a queue-free behavioural model is compared
// against the DUT every cycle, plus hand-computed literal expectations.

module tb_write_bus_arbiter;

   localparam int WordWidth    = 32;
   localparam int RegAddrWidth = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic stall = 1'b0;
   logic [2:0] req = 3'b000;
   logic [3*WordWidth-1:0] reqData = '0;
   logic [3*RegAddrWidth-1:0] reqDest = '0;
   logic [RegAddrWidth-1:0] leftAddr = '0;
   logic [RegAddrWidth-1:0] rightAddr = '0;
   logic [RegAddrWidth-1:0] thirdAddr = '0;
   logic leftValid = 1'b0;
   logic rightValid = 1'b0;
   logic thirdValid = 1'b0;

   logic [2:0] grant;
   logic [WordWidth-1:0] writeBus;
   logic [RegAddrWidth-1:0] writeDest;
   logic writeValid;
   logic toLeft;
   logic toRight;
   logic toThird;

   int assertionCount = 0;
   int failCount = 0;
   bit checking = 1'b0;

   int mPtr = 0;
   bit mValid = 1'b0;
   logic [WordWidth-1:0] mData = '0;
   logic [RegAddrWidth-1:0] mDest = '0;

   write_bus_arbiter #(
      .WordWidth(WordWidth),
      .RegAddrWidth(RegAddrWidth),
      .NoForwardReg(15)
   ) dut (
      .in_Clock(clock),
      .in_Reset(reset),
      .in_Stall(stall),
      .in_Req(req),
      .in_ReqData(reqData),
      .in_ReqDest(reqDest),
      .out_Grant(grant),
      .out_WriteBus(writeBus),
      .out_WriteDest(writeDest),
      .out_WriteValid(writeValid),
      .in_LeftReadAddr(leftAddr),
      .in_RightReadAddr(rightAddr),
      .in_ThirdReadAddr(thirdAddr),
      .in_LeftReadValid(leftValid),
      .in_RightReadValid(rightValid),
      .in_ThirdReadValid(thirdValid),
      .out_WriteToLeftRead(toLeft),
      .out_WriteToRightRead(toRight),
      .out_WriteToThirdRead(toThird)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clock = ~clock;

   // Model: walk the requesters starting at the pointer, first one requesting wins.
   function automatic int expectedGrantIdx();
      int i;
      if (reset || stall) return -1;
      for (int k = 0; k < 3; k++) begin
         i = (mPtr + k) % 3;
         if (req[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [2:0] expectedGrant();
      logic [2:0] v;
      int g;
      v = 3'b000;
      g = expectedGrantIdx();
      if (g >= 0) v[g] = 1'b1;
      return v;
   endfunction

   function automatic logic expectedForward(input logic [RegAddrWidth-1:0] addr, input logic used);
      return mValid && !reset && used && (addr == mDest) && (mDest != 4'd15);
   endfunction

   // Model state advances on every rising edge from the inputs held across it.
   task automatic modelStep();
      int g;
      g = expectedGrantIdx();
      if (reset) begin
         mPtr = 0;
         mValid = 1'b0;
         mData = '0;
         mDest = '0;
      end else if (!stall) begin
         if (g >= 0) begin
            mData = reqData[g*WordWidth +: WordWidth];
            mDest = reqDest[g*RegAddrWidth +: RegAddrWidth];
            mValid = 1'b1;
            mPtr = (g + 1) % 3;
         end else begin
            mValid = 1'b0;
         end
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertionCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic compareAll();
      checkOutput("grant", 32'(grant), 32'(expectedGrant()));
      checkOutput("writeValid", 32'(writeValid), 32'(mValid));
      checkOutput("writeBus", writeBus, mData);
      checkOutput("writeDest", 32'(writeDest), 32'(mDest));
      checkOutput("fwdLeft", 32'(toLeft), 32'(expectedForward(leftAddr, leftValid)));
      checkOutput("fwdRight", 32'(toRight), 32'(expectedForward(rightAddr, rightValid)));
      checkOutput("fwdThird", 32'(toThird), 32'(expectedForward(thirdAddr, thirdValid)));
   endtask

   initial forever begin
      @(posedge clock);
      modelStep();
   end

   initial forever begin
      @(negedge clock);
      if (checking) compareAll();
   end

   task automatic applyStimulus(input logic [2:0] r, input logic s, input logic rst);
      req = r;
      stall = s;
      reset = rst;
   endtask

   task automatic setRequester(input int i, input logic [WordWidth-1:0] d, input logic [RegAddrWidth-1:0] a);
      reqData[i*WordWidth +: WordWidth] = d;
      reqDest[i*RegAddrWidth +: RegAddrWidth] = a;
   endtask

   task automatic setReads(input logic [3:0] la, input logic lv, input logic [3:0] ra, input logic rv,
                           input logic [3:0] ta, input logic tv);
      leftAddr = la;
      leftValid = lv;
      rightAddr = ra;
      rightValid = rv;
      thirdAddr = ta;
      thirdValid = tv;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic sample();
      @(negedge clock);
   endtask

   // Directed sequence; every literal below is worked out by hand from the arbitration rules.
   initial begin
      logic [2:0] rrGrantExp [6];
      logic [31:0] rrBusExp [6];
      rrGrantExp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      rrBusExp = '{32'h0, 32'hA, 32'hB, 32'hC, 32'hA, 32'hB};

      $display("[TB] start");
      setRequester(0, 32'hA, 4'd1);
      setRequester(1, 32'hB, 4'd2);
      setRequester(2, 32'hC, 4'd3);
      setReads(4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b0);
      applyStimulus(3'b111, 1'b0, 1'b1);

      tick();
      checking = 1'b1;
      sample();
      checkOutput("rstGrant", 32'(grant), 32'h0);
      checkOutput("rstValid", 32'(writeValid), 32'h0);
      checkOutput("rstBus", writeBus, 32'h0);
      checkOutput("rstFwd", 32'({toLeft, toRight, toThird}), 32'h0);
      tick();
      applyStimulus(3'b111, 1'b0, 1'b0);

      $display("[TB] round-robin");
      for (int c = 0; c < 6; c++) begin
         sample();
         checkOutput("rrGrant", 32'(grant), 32'(rrGrantExp[c]));
         if (c > 0) checkOutput("rrBus", writeBus, rrBusExp[c]);
         tick();
      end
      applyStimulus(3'b000, 1'b0, 1'b0);
      sample();
      checkOutput("rrLastBus", writeBus, 32'hC);
      checkOutput("rrIdleGrant", 32'(grant), 32'h0);

      $display("[TB] single requester");
      tick();
      setRequester(1, 32'h1234, 4'd5);
      applyStimulus(3'b010, 1'b0, 1'b0);
      sample();
      checkOutput("singleGrant", 32'(grant), 32'b010);
      checkOutput("idleValid", 32'(writeValid), 32'h0);
      tick();
      applyStimulus(3'b000, 1'b0, 1'b0);
      sample();
      checkOutput("singleBus", writeBus, 32'h1234);
      checkOutput("singleDest", 32'(writeDest), 32'd5);
      checkOutput("singleValid", 32'(writeValid), 32'h1);
      tick();
      sample();
      checkOutput("singleIdleValid", 32'(writeValid), 32'h0);
      checkOutput("singleHoldDest", 32'(writeDest), 32'd5);

      $display("[TB] forwarding");
      setRequester(0, 32'h77, 4'd7);
      setReads(4'd7, 1'b1, 4'd7, 1'b1, 4'd7, 1'b0);
      applyStimulus(3'b001, 1'b0, 1'b0);
      sample();
      checkOutput("fwdR7Grant", 32'(grant), 32'b001);
      tick();
      applyStimulus(3'b000, 1'b0, 1'b0);
      sample();
      checkOutput("fwdR7", 32'({toLeft, toRight, toThird}), 32'b110);
      setRequester(0, 32'hF, 4'd15);
      setReads(4'd15, 1'b1, 4'd15, 1'b1, 4'd15, 1'b1);
      applyStimulus(3'b001, 1'b0, 1'b0);
      tick();
      applyStimulus(3'b000, 1'b0, 1'b0);
      sample();
      checkOutput("pcDest", 32'(writeDest), 32'd15);
      checkOutput("pcValid", 32'(writeValid), 32'h1);
      checkOutput("pcFwd", 32'({toLeft, toRight, toThird}), 32'h0);

      $display("[TB] stall");
      setRequester(1, 32'h33, 4'd3);
      setReads(4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
      applyStimulus(3'b010, 1'b0, 1'b0);
      tick();
      setRequester(2, 32'hCC, 4'd4);
      applyStimulus(3'b100, 1'b1, 1'b0);
      for (int c = 0; c < 3; c++) begin
         sample();
         checkOutput("stallGrant", 32'(grant), 32'h0);
         checkOutput("stallDest", 32'(writeDest), 32'd3);
         checkOutput("stallValid", 32'(writeValid), 32'h1);
         checkOutput("stallFwd", 32'(toLeft), 32'h1);
         tick();
      end
      applyStimulus(3'b100, 1'b0, 1'b0);
      sample();
      checkOutput("stallRelGrant", 32'(grant), 32'b100);
      tick();
      applyStimulus(3'b000, 1'b0, 1'b0);
      sample();
      checkOutput("stallRelBus", writeBus, 32'hCC);
      checkOutput("stallRelDest", 32'(writeDest), 32'd4);

      $display("[TB] reset mid-stream");
      setRequester(0, 32'h99, 4'd9);
      setReads(4'd9, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
      applyStimulus(3'b001, 1'b0, 1'b0);
      sample();
      checkOutput("midGrant", 32'(grant), 32'b001);
      tick();
      applyStimulus(3'b001, 1'b0, 1'b1);
      sample();
      checkOutput("midRstGrant", 32'(grant), 32'h0);
      checkOutput("midRstFwd", 32'(toLeft), 32'h0);
      tick();
      setRequester(1, 32'h11, 4'd1);
      applyStimulus(3'b011, 1'b0, 1'b0);
      sample();
      checkOutput("midRstValid", 32'(writeValid), 32'h0);
      checkOutput("midRstBus", writeBus, 32'h0);
      checkOutput("postMidGrant", 32'(grant), 32'b001);
      tick();
      applyStimulus(3'b010, 1'b0, 1'b0);
      sample();
      checkOutput("postMidBus", writeBus, 32'h99);
      checkOutput("postMidGrant1", 32'(grant), 32'b010);
      tick();
      applyStimulus(3'b000, 1'b0, 1'b0);
      sample();
      checkOutput("postMidBus1", writeBus, 32'h11);
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", assertionCount, failCount);
      $finish;
   end

endmodule
